// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// A grant captures the winner's word, pulses Transmit/Ack, then holds off
// further grants for FRAME_CYCLES+GAP_CYCLES clocks. The UART has no busy
// flag, so the frame window is timed purely by a cycle counter.
//
// Optional build macro: UART_ARB_PRIORITY_EN
//   defined   -> requester 0 always wins when it requests; the others share
//                round-robin only while Req[0] is low (starvation intended).
//   undefined -> pure round-robin across all requesters.
module uart_tx_arbiter #(
    parameter int WORD_LENGTH  = 8,
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = WORD_LENGTH + 3,
    parameter int GAP_CYCLES   = 1,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] Data_In,
    output logic [NUM_REQ-1:0]             Ack,
    output logic [WORD_LENGTH-1:0]         Parallel_In,
    output logic                           Transmit,
    output logic [ID_W-1:0]                Grant_Id,
    output logic                           Busy,
    output logic                           Done
);

    // Length of the blocking window: frame plus enforced idle gap.
    localparam int WIN   = FRAME_CYCLES + GAP_CYCLES;
    localparam int CNT_W = (WIN > 1) ? $clog2(WIN) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [ID_W-1:0]  last;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  cand;

    // Pick the next winner: first requester found scanning upward from last+1.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise synthesis infers a latch to hold the old value.
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last) + k) % NUM_REQ);
            if (!found && Req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`ifdef UART_ARB_PRIORITY_EN
        // Requester 0 overrides the rotation whenever it is asking.
        if (Req[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

    // Grant/window sequencer; every output is a register driven from here.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (!Reset) begin
            state       <= IDLE;
            count       <= '0;
            last        <= ID_W'(NUM_REQ - 1);
            Ack         <= '0;
            Parallel_In <= '0;
            Transmit    <= 1'b0;
            Grant_Id    <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            // Pulse outputs default low; they are raised for one cycle only.
            Ack      <= '0;
            Transmit <= 1'b0;
            Done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        Parallel_In <= Data_In[int'(winner)*WORD_LENGTH +: WORD_LENGTH];
                        Grant_Id    <= winner;
                        Ack         <= NUM_REQ'(1) << winner;
                        Transmit    <= 1'b1;
                        last        <= winner;
                        count       <= CNT_W'(WIN - 1);
                        Busy        <= 1'b1;
                        // A one-cycle window ends in the same cycle it starts.
                        Done        <= (WIN == 1);
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count - CNT_W'(1);
                        // Raise Done so it is visible in the counter-zero cycle.
                        if (count == CNT_W'(1)) begin
                            Done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` requesters. It captures one requester's word, drives the UART `Parallel_In`/`Transmit` pair, and blocks further grants for a full frame window plus a configurable gap. The UART exposes no transmit-busy flag, so the block sequences frames from a fixed cycle count. It sits between client logic and the `UART` instance's transmit side.

## Interface
- `WORD_LENGTH`, 8, data bits per frame; matches the UART instance.
- `NUM_REQ`, 4, number of requesters, 2..8.
- `FRAME_CYCLES`, `WORD_LENGTH+3`, clocks per UART frame (start + data + parity + stop).
- `GAP_CYCLES`, 1, idle clocks enforced after each frame, ≥0.

- `Clk`  in  1  single clock.
- `Reset`  in  1  synchronous, active-low reset.
- `Req`  in  `NUM_REQ`  request bits; bit i held high until `Ack[i]`.
- `Data_In`  in  `NUM_REQ*WORD_LENGTH`  requester i word at `[i*WORD_LENGTH +: WORD_LENGTH]`.
- `Ack`  out  `NUM_REQ`  one-hot, one-cycle pulse: word captured.
- `Parallel_In`  out  `WORD_LENGTH`  word to the UART.
- `Transmit`  out  1  one-cycle start pulse to the UART.
- `Grant_Id`  out  `max(1,clog2(NUM_REQ))`  index of the last granted requester.
- `Busy`  out  1  frame window active.
- `Done`  out  1  one-cycle pulse on the last cycle of the window.

## Operation
- States: IDLE and WAIT.
- In IDLE, if `Req != 0`, the block picks winner w by round-robin. The search starts at `(last+1) mod NUM_REQ`. `last` resets to `NUM_REQ-1`, so requester 0 wins first.
- On that clock edge it registers all of the following:
  - `Parallel_In <= Data_In[w]`
  - `Grant_Id <= w`
  - `Ack <= onehot(w)`
  - `Transmit <= 1`
  - `last <= w`
  - counter `<= FRAME_CYCLES+GAP_CYCLES-1`
  - state goes to WAIT.
- In WAIT:
  - `Ack` and `Transmit` are 0 after their first cycle.
  - The counter decrements each clock.
  - At counter 0: `Done=1` for that cycle, then go to IDLE.
- `Req` is ignored outside IDLE. `Data_In` is sampled only on the grant edge.
- `Parallel_In` and `Grant_Id` hold their value until the next grant.
- If a requester drops `Req` before `Ack`, the request is withdrawn and nothing is sent.
- Reset values: `Ack=0`, `Parallel_In=0`, `Transmit=0`, `Grant_Id=0`, `Busy=0`, `Done=0`. State is IDLE, counter 0, `last=NUM_REQ-1`.
- Reset asserted mid-WAIT aborts the window; the next cycle is IDLE with all outputs at reset values. A frame already shifting inside the UART is not cancelled by this block.
- Simultaneous requests: exactly one grant per window; the others keep waiting.

## Timing
- Request high in IDLE at cycle t → `Ack`, `Transmit`, `Busy` high at t+1.
- `Busy` is high from t+1 through t+FRAME_CYCLES+GAP_CYCLES; `Done` pulses at t+FRAME_CYCLES+GAP_CYCLES.
- Earliest next `Transmit` is at t+FRAME_CYCLES+GAP_CYCLES+2. With the defaults, consecutive `Transmit` pulses are 13 cycles apart.
- All outputs are registered. There is no combinational path from `Req` to `Ack`.

## Configuration
- `UART_ARB_PRIORITY_EN` defined:
  - Requester 0 is fixed highest priority.
  - The remaining requesters are round-robin among themselves, and only when `Req[0]=0`.
  - Requester 0 can starve the others; this is intended.
- `UART_ARB_PRIORITY_EN` undefined: pure round-robin across all requesters, as described above.

## Test plan
- Reset: hold `Reset=0` for 3 clocks with `Req=4'hF` → all outputs 0; no `Ack` until one cycle after `Reset=1`.
- Single request: `Req[2]=1`, `Data_In[2]=8'h09` in IDLE at cycle 5 → at cycle 6, `Transmit=1`, `Ack=4'b0100`, `Parallel_In=8'h09`, `Grant_Id=2`. `Busy` is high cycles 6–17 and `Done=1` at cycle 17.
- Fairness: `Req=4'hF` held, re-asserted after each `Ack` → grant order 0,1,2,3,0 with `Transmit` spaced 13 cycles apart.
- Pointer: after a grant to 1, `Req=4'b1010` → next grant 3, then 1.
- Reset mid-WAIT: `Reset=0` at cycle 4 of a window → next cycle `Busy=0`. With `Req[1]` held, `Ack[1]` fires one cycle after reset release.
- Priority build (`UART_ARB_PRIORITY_EN` defined): `Req=4'b0101` held continuously → every grant goes to 0. After `Req[0]` drops, the next grant goes to 2.
